// File: rtl/key_debounce_if.sv
// Signal bundle between a debounced-key consumer and the key_debounce block.
// The master drives the raw key and sample qualifier; the slave returns the clean level and edge pulses.
interface key_debounce_if;
    logic din;
    logic sample_en;
    logic q;
    logic qbar;
    logic rise;
    logic fall;

    modport master (
        output din,
        output sample_en,
        input  q,
        input  qbar,
        input  rise,
        input  fall
    );

    modport slave (
        input  din,
        input  sample_en,
        output q,
        output qbar,
        output rise,
        output fall
    );
endinterface

// File: rtl/key_debounce.sv
// Turns a bouncy asynchronous key input into a clean registered level with one-cycle rise/fall pulses.
// Two-flop synchronizer feeding a four-state stability FSM with a saturating-free check counter.
module key_debounce #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input logic           clk,
    input logic           reset,
    key_debounce_if.slave bus
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             qbar_q;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             commitRise, commitFall;

    // Synchronizer runs every edge; only the FSM and counter honour sample_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            qbar_q  <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= bus.din;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            qbar_q  <= ~q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        commitRise = 1'b0;
        commitFall = 1'b0;
        if (bus.sample_en) begin
            case (state_q)
                STABLE_LOW: begin
                    if (s2_q) begin
                        state_d = CHECK_HIGH;
                        cnt_d   = '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!s2_q) begin
                        state_d = STABLE_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = STABLE_HIGH;
                        cnt_d      = '0;
                        commitRise = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HIGH: begin
                    if (!s2_q) begin
                        state_d = CHECK_LOW;
                        cnt_d   = '0;
                    end
                end
                CHECK_LOW: begin
                    if (s2_q) begin
                        state_d = STABLE_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d    = STABLE_LOW;
                        cnt_d      = '0;
                        commitFall = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The debounced level follows the high-side states, so q and the pulse land on the same edge.
    always_comb begin
        q_d    = (state_d == STABLE_HIGH) || (state_d == CHECK_LOW);
        rise_d = commitRise;
        fall_d = commitFall;
    end

    assign bus.q    = q_q;
    assign bus.qbar = qbar_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with STABLE_CYCLES=4, so a held level commits 7 edges after it is applied.
// Inputs change on the falling edge; outputs are checked on the falling edge after each rising edge.
module tb_key_debounce;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    key_debounce_if bus ();

    key_debounce #(
        .STABLE_CYCLES(4),
        .CNT_W        (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.sample_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.din       = 1'b1;
        bus.sample_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            nChecks++;
            if (bus.q !== (e >= 7)) begin
                nFails++;
                $display("[TB] FAIL reset_release_q edge %0d: got %b expected %b", e, bus.q, (e >= 7));
            end
            nChecks++;
            if (bus.rise !== (e == 7)) begin
                nFails++;
                $display("[TB] FAIL reset_release_rise edge %0d: got %b expected %b", e, bus.rise, (e == 7));
            end
        end
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if ({bus.q, bus.qbar, bus.rise, bus.fall} !== 4'b0100) begin
            nFails++;
            $display("[TB] FAIL async_reset {q,qbar,rise,fall}: got %b expected 0100",
                     {bus.q, bus.qbar, bus.rise, bus.fall});
        end
        @(negedge clk);
        bus.din = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic test_clean_press();
        resetDut();
        bus.din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            nChecks++;
            if ({bus.q, bus.qbar, bus.rise, bus.fall} !== {(e >= 7), (e < 7), (e == 7), 1'b0}) begin
                nFails++;
                $display("[TB] FAIL press edge %0d {q,qbar,rise,fall}: got %b expected %b", e,
                         {bus.q, bus.qbar, bus.rise, bus.fall}, {(e >= 7), (e < 7), (e == 7), 1'b0});
            end
        end
        bus.din = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            nChecks++;
            if ({bus.q, bus.qbar, bus.rise, bus.fall} !== {(e < 7), (e >= 7), 1'b0, (e == 7)}) begin
                nFails++;
                $display("[TB] FAIL release edge %0d {q,qbar,rise,fall}: got %b expected %b", e,
                         {bus.q, bus.qbar, bus.rise, bus.fall}, {(e < 7), (e >= 7), 1'b0, (e == 7)});
            end
        end
    endtask

    task automatic test_bounce();
        resetDut();
        for (int c = 1; c <= 5; c++) begin
            bus.din = (c <= 3);
            step();
            nChecks++;
            if ({bus.q, bus.rise} !== 2'b00) begin
                nFails++;
                $display("[TB] FAIL bounce_excursion cycle %0d {q,rise}: got %b expected 00", c, {bus.q, bus.rise});
            end
        end
        bus.din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            nChecks++;
            if ({bus.q, bus.rise} !== {(e >= 7), (e == 7)}) begin
                nFails++;
                $display("[TB] FAIL bounce_settle edge %0d {q,rise}: got %b expected %b", e,
                         {bus.q, bus.rise}, {(e >= 7), (e == 7)});
            end
        end
    endtask

    task automatic test_late_reject();
        int riseCount;
        resetDut();
        riseCount = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.din = (e <= 4);
            step();
            if (bus.rise === 1'b1) riseCount++;
            nChecks++;
            if (bus.q !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL late_reject_q edge %0d: got %b expected 0", e, bus.q);
            end
        end
        nChecks++;
        if (riseCount !== 0) begin
            nFails++;
            $display("[TB] FAIL late_reject_rise_count: got %0d expected 0", riseCount);
        end

        resetDut();
        riseCount = 0;
        for (int e = 1; e <= 14; e++) begin
            bus.din = (e <= 5);
            step();
            if (bus.rise === 1'b1) riseCount++;
            nChecks++;
            if ({bus.rise, bus.fall} !== {(e == 7), (e == 12)}) begin
                nFails++;
                $display("[TB] FAIL five_cycle_pulse edge %0d {rise,fall}: got %b expected %b", e,
                         {bus.rise, bus.fall}, {(e == 7), (e == 12)});
            end
        end
        nChecks++;
        if (riseCount !== 1) begin
            nFails++;
            $display("[TB] FAIL five_cycle_rise_count: got %0d expected 1", riseCount);
        end
    endtask

    task automatic test_enable_gating();
        resetDut();
        bus.din = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            bus.sample_en = ((n % 3) == 0);
            step();
            nChecks++;
            if ({bus.q, bus.rise} !== {(n >= 15), (n == 15)}) begin
                nFails++;
                $display("[TB] FAIL enable_gating edge %0d {q,rise}: got %b expected %b", n,
                         {bus.q, bus.rise}, {(n >= 15), (n == 15)});
            end
        end
        bus.sample_en = 1'b1;
    endtask

    task automatic test_reset_mid_check();
        resetDut();
        bus.din = 1'b1;
        for (int e = 1; e <= 5; e++) step();
        nChecks++;
        if (dut.cnt_q !== 5'd2) begin
            nFails++;
            $display("[TB] FAIL mid_check_cnt_before_reset: got %0d expected 2", dut.cnt_q);
        end
        #2 reset = 1'b1;
        #1;
        nChecks++;
        if ({dut.cnt_q, bus.q, bus.qbar} !== {5'd0, 1'b0, 1'b1}) begin
            nFails++;
            $display("[TB] FAIL mid_check_reset {cnt,q,qbar}: got %b expected %b",
                     {dut.cnt_q, bus.q, bus.qbar}, {5'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            nChecks++;
            if ({bus.q, bus.rise} !== {(e >= 7), (e == 7)}) begin
                nFails++;
                $display("[TB] FAIL mid_check_restart edge %0d {q,rise}: got %b expected %b", e,
                         {bus.q, bus.rise}, {(e >= 7), (e == 7)});
            end
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.sample_en = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_late_reject();
        test_enable_gating();
        test_reset_mid_check();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces one asynchronous, bouncy 1-bit input such as a push button or switch into a clean registered level, with single-cycle rise/fall pulses. Sits directly upstream of the flip-flop stages (D, T, enable and set/reset variants) so their `d`/`t`/`en` inputs see a glitch-free, clock-aligned signal. Internally it is a 2-flop synchronizer, a 4-state FSM and a stability counter.

## Interface
- `STABLE_CYCLES`, default 16: consecutive qualified samples the new level must hold before `q` changes. Legal range is ≥2 and ≤2^`CNT_W`.
- `CNT_W`, default 5: width of the stability counter.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `din`  in  1  raw asynchronous input; no timing relation to `clk`.
- `sample_en`  in  1  qualifier for FSM/counter evaluation; tie to 1 for full rate.
- `q`  out  1  debounced level, registered.
- `qbar`  out  1  always `~q`, registered.
- `rise`  out  1  one-cycle pulse when `q` goes 0→1.
- `fall`  out  1  one-cycle pulse when `q` goes 1→0.

## Operation
- Synchronizer: `s1 <= din`, `s2 <= s1` on every edge, regardless of `sample_en`. The FSM uses only `s2`.
- States:
  - `STABLE_LOW` (q=0)
  - `CHECK_HIGH` (q=0, candidate 1)
  - `STABLE_HIGH` (q=1)
  - `CHECK_LOW` (q=1, candidate 0)
- All FSM and counter actions below occur only on edges with `sample_en`=1. With `sample_en`=0, state, `cnt` and `q` hold; `rise`/`fall` are 0.
- `STABLE_LOW`: if `s2`=1, go to `CHECK_HIGH` with `cnt`=0. Otherwise stay.
- `CHECK_HIGH`:
  - if `s2`=0, go to `STABLE_LOW`, `cnt`=0, no pulse (glitch rejected);
  - else if `cnt`==`STABLE_CYCLES`-1, commit: `q`=1, `qbar`=0, `rise`=1 for this cycle, go to `STABLE_HIGH`, `cnt`=0;
  - else `cnt`+1.
- `STABLE_HIGH` / `CHECK_LOW`: mirror image of the above, with `fall` as the pulse.
- `cnt` never wraps: it is cleared on every state exit and never exceeds `STABLE_CYCLES`-1.
- `rise` and `fall` are never both 1. Each pulse is exactly one `clk` cycle and coincides with the cycle `q` first shows the new value.
- Reset (async, takes effect immediately, including mid-check):
  - `s1`=`s2`=0, state `STABLE_LOW`, `cnt`=0;
  - `q`=0, `qbar`=1, `rise`=0, `fall`=0;
  - no pulse is generated on reset release, even if `din`=1. A held-high `din` is then debounced normally: `rise` fires after the full latency.

## Timing
- Latency with `sample_en`=1, counting from the first edge that samples a new `din` value:
  - edge 1: `s1` updates;
  - edge 2: `s2` updates;
  - edge 3: FSM enters CHECK;
  - edge 3+`STABLE_CYCLES`: `q` flips and the pulse asserts.
  - Total: `STABLE_CYCLES`+3 edges (19 for the default).
- A `din` excursion whose `s2` image lasts ≤`STABLE_CYCLES` edges never changes `q`.
- Rejection is tested on every qualified edge, including the commit edge. If `s2` reverts on the edge where `cnt`==`STABLE_CYCLES`-1, the block rejects and does not commit.
- With `sample_en` pulsing 1-in-K, the latency in qualified samples is unchanged. The synchronizer stays at full rate.
- `q` and `qbar` are registered outputs, never combinational from `din`.

## Test plan
Bench overrides `STABLE_CYCLES`=4, `sample_en`=1 unless stated.
- Reset: assert `reset` mid-cycle → `q`=0, `qbar`=1, `rise`=`fall`=0 immediately, without waiting for `clk`. Release with `din`=1 → `rise` pulses once, 7 edges after release, and `q`=1 from then on.
- Clean press: `din` 0→1 held → `q`=1 and `rise`=1 on edge 7, `rise`=0 on edge 8. Then `din` 1→0 held → `fall`=1 on edge 7, `q`=0.
- Bounce: `din`=1 for 3 cycles, then 0, then 1 held → no pulse from the first excursion. `rise` fires 7 edges after the final 0→1.
- Late reject: `din` high for exactly 4 cycles, then low → `q` stays 0, `rise` never asserts. A 5-cycle high pulse → `rise` asserts once.
- Enable gating: `sample_en` high every 3rd cycle, `din` 0→1 held → `q` rises after 5 qualified samples following synchronization. `q` stays constant while `sample_en`=0.
- Reset mid-check: `din`=1 and `reset` pulsed when `cnt`=2 → `cnt` cleared, `q`=0. The full 7-edge latency restarts after release.
